regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port (RegWrite/writeReg/writeData) between two
//   writeback requesters: the memory load path and the ALU result path.
//   Loads always win; ALU writes are buffered in a small in-order FIFO and drained on free cycles.
//   Also reports whether either read register has a write still pending, so decode can stall.
//   Sits between the execute/memory stages and the Register block.
// PARAMETERS
//   DATA_W      32  width of write data
//   ADDR_W      5   width of register index
//   FIFO_DEPTH  2   ALU pending-write entries (power of two, >=2)
// PORTS
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-high reset
//   mem_valid  in   1       load writeback request
//   mem_reg    in   ADDR_W  load destination register
//   mem_data   in   DATA_W  load data
//   alu_valid  in   1       ALU writeback request
//   alu_ready  out  1       ALU request accepted this cycle (valid & ready)
//   alu_reg    in   ADDR_W  ALU destination register
//   alu_data   in   DATA_W  ALU result
//   readReg1   in   ADDR_W  decode read index 1 (hazard lookup)
//   readReg2   in   ADDR_W  decode read index 2 (hazard lookup)
//   pend1      out  1       write to readReg1 queued or on the port this cycle
//   pend2      out  1       same for readReg2
//   RegWrite   out  1       register-file write enable (registered)
//   writeReg   out  ADDR_W  register-file write index (registered)
//   writeData  out  DATA_W  register-file write data (registered)
// BEHAVIOUR
//   - Reset: RegWrite=0, writeReg=0, writeData=0, FIFO empty (count=0, ptrs=0), state EMPTY.
//   - Loads are never back-pressured: mem_valid is always consumed in the cycle it is high.
//   - alu_ready = (count < FIFO_DEPTH) | (count==FIFO_DEPTH & !mem_valid), i.e. full FIFO
//     accepts only when the head pops in the same cycle.
//   - Issue per rising edge, exactly one source, priority:
//       1. mem_valid            -> port <= {1, mem_reg, mem_data}
//       2. FIFO non-empty       -> port <= head; pop
//       3. alu_valid & FIFO empty (bypass) -> port <= {1, alu_reg, alu_data}
//       4. none                 -> RegWrite <= 0 (writeReg/writeData hold)
//   - Accepted ALU request not issued this edge is pushed to FIFO tail; issue order of
//     ALU writes is strictly acceptance order. Simultaneous push+pop: count unchanged.
//   - Latency: request to RegWrite = 1 cycle minimum; ALU worst case 1+count+load cycles.
//   - Register 0: requests to reg 0 are accepted/consumed normally but issue RegWrite=0.
//   - State (from count): EMPTY (0) -> PARTIAL on push w/o pop; PARTIAL -> FULL on push w/o
//     pop at count=DEPTH-1; FULL -> PARTIAL on pop w/o push; PARTIAL -> EMPTY on last pop.
//     Pointers wrap modulo FIFO_DEPTH.
//   - pendN (combinational from registered state) = readRegN!=0 & (readRegN matches any valid
//     FIFO entry | (RegWrite & writeReg==readRegN)).
//     Incoming requests this cycle are NOT included.
//   - Same-register load/ALU ordering is caller's responsibility; arbiter does not reorder
//     or merge.
//   - Reset asserted mid-operation: FIFO contents discarded, outputs return to reset values
//     immediately (async).
//   - Overflow is impossible by construction; push when full and not popping is a bench
//     assertion failure.
// TESTING
//   1. reset=1 with alu_valid=1 -> RegWrite=0, alu_ready still legal, no write after release
//      until next edge.
//   2. alu_valid=1, alu_reg=5, alu_data=32'h1234, idle -> next edge RegWrite=1, writeReg=5,
//      writeData=32'h1234.
//   3. mem(reg 3, 0xAA) and alu(reg 4, 0xBB) same cycle -> edge1 writes r3=0xAA;
//      edge2 writes r4=0xBB.
//   4. mem_valid held 3 cycles, alu pushes r6,r7 then r8 -> alu_ready=0 on third while full;
//      after mem drops writes r6, r7, r8 in order.
//   5. alu to reg 0 -> consumed, RegWrite=0; readReg1=0 -> pend1=0 always.
//   6. FIFO holds r9, readReg1=9, readReg2=10 -> pend1=1, pend2=0; pend1 clears after r9 write
//      cycle ends.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: loads win the single write port,
// ALU results wait in a small in-order FIFO or bypass it when idle.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic              pend1,
  output logic              pend2,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_t;

  state_t state, stateNext;

  logic [ADDR_W-1:0] fifoReg  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifoData [FIFO_DEPTH];
  logic [PW-1:0]     headPtr, tailPtr, idx;
  logic [CW-1:0]     count;
  logic fifoEmpty, fifoFull;
  logic accept, bypass, doPop, doPush;
  logic hit1, hit2;

  assign fifoEmpty = (state == EMPTY);
  assign fifoFull  = (state == FULL);
  // A full FIFO takes a new entry only when its head leaves this edge
  assign alu_ready = !fifoFull | !mem_valid;
  assign accept    = alu_valid & alu_ready;
  assign doPop     = !mem_valid & !fifoEmpty;
  assign bypass    = !mem_valid & fifoEmpty & alu_valid;
  assign doPush    = accept & !bypass;

  // Occupancy state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= stateNext;
  end

  // Occupancy transitions driven by push/pop
  always_comb begin
    stateNext = state;
    unique case (state)
      EMPTY: begin
        if (doPush) stateNext = PARTIAL;
      end
      PARTIAL: begin
        if (doPush & !doPop & (count == DEPTH_C - ONE_C))
          stateNext = FULL;
        else if (doPop & !doPush & (count == ONE_C))
          stateNext = EMPTY;
      end
      FULL: begin
        if (doPop & !doPush) stateNext = PARTIAL;
      end
      default: stateNext = EMPTY;
    endcase
  end

  // Pointers and count; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doPop)  headPtr <= headPtr + PW'(1);
      if (doPush) tailPtr <= tailPtr + PW'(1);
      if (doPush & !doPop)      count <= count + ONE_C;
      else if (doPop & !doPush) count <= count - ONE_C;
    end
  end

  // FIFO storage needs no reset; validity comes from count
  always_ff @(posedge clk) begin
    if (doPush) begin
      fifoReg[tailPtr]  <= alu_reg;
      fifoData[tailPtr] <= alu_data;
    end
  end

  // Write port: load, then FIFO head, then ALU bypass; r0 never writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (mem_valid) begin
      RegWrite  <= (mem_reg != '0);
      writeReg  <= mem_reg;
      writeData <= mem_data;
    end else if (!fifoEmpty) begin
      RegWrite  <= (fifoReg[headPtr] != '0);
      writeReg  <= fifoReg[headPtr];
      writeData <= fifoData[headPtr];
    end else if (alu_valid) begin
      RegWrite  <= (alu_reg != '0);
      writeReg  <= alu_reg;
      writeData <= alu_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  // Hazard lookup over valid FIFO entries, head first
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = headPtr + PW'(i);
      if (CW'(i) < count) begin
        if (fifoReg[idx] == readReg1) hit1 = 1'b1;
        if (fifoReg[idx] == readReg2) hit2 = 1'b1;
      end
    end
  end

  assign pend1 = (readReg1 != '0) &
                 (hit1 | (RegWrite & (writeReg == readReg1)));
  assign pend2 = (readReg2 != '0) &
                 (hit2 | (RegWrite & (writeReg == readReg2)));

endmodule
